imem_loader: RTL
================

# imem_loader

Boot-time instruction-memory writer: the producing end of the fetch path, whose reader is the CPU's PC/instruction-memory fetch unit. It accepts a byte stream from a host link (UART receiver or testbench), assembles little-endian 32-bit instruction words, and writes them sequentially into the instruction memory's write port. It holds the CPU in reset until the whole image is written, then releases it so fetch starts from `BASE_ADDR`.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: instruction memory capacity in 32-bit words; the largest image accepted.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written; must equal the PC reset value.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset; priority over all other inputs.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: loader can accept a byte this cycle.
- `mem_we` output 1: one-cycle write strobe to instruction memory.
- `mem_addr` output `DATA_BUS`: byte address of the word being written.
- `mem_wdata` output `DATA_BUS`: instruction word.
- `cpu_hold` output 1: drives CPU `rst`; high until the load completes.
- `done` output 1: image fully written, sticky until `rst`.
- `error` output 1: bad header, sticky until `rst`.

## Operation
- Stream format: 4-byte little-endian word count N, then 4·N bytes, each word little-endian (first byte → bits 7:0).
- Byte transfer occurs on a rising edge with `in_valid && in_ready`; there is no other handshake.
- States: `HDR`, `CHECK`, `LOAD`, `WRITE`, `DONE`, `ERROR`.
  - `HDR`: collect 4 bytes into the count register. After the 4th byte, go to `CHECK`.
  - `CHECK` (1 cycle): if N==0, go to `DONE`. If N>`DEPTH_WORDS`, go to `ERROR`. Otherwise go to `LOAD`.
  - `LOAD`: collect 4 bytes into the word register. After the 4th byte, go to `WRITE`.
  - `WRITE` (1 cycle): `mem_we`=1, with `mem_addr`=`BASE_ADDR`+4·k and `mem_wdata`=the assembled word. Increment k. If k+1==N, go to `DONE`; otherwise go to `LOAD`.
  - `DONE`/`ERROR`: terminal until `rst`. Further bytes are never accepted.
- `in_ready` = 1 only in `HDR` and `LOAD`.
- `cpu_hold` = 0 only in `DONE`. In `ERROR` it stays 1.
- Arithmetic:
  - k and N are held as 32-bit unsigned values.
  - The address add wraps modulo 2^32. Wrap is unreachable when N≤`DEPTH_WORDS`.
  - The byte counter is 2 bits and wraps 3→0 on the 4th byte.
- `mem_addr` and `mem_wdata` hold their last values outside `WRITE`.

## Timing
- Reset values (the cycle after `rst` is sampled high): state=`HDR`, `in_ready`=1, `mem_we`=0, `mem_addr`=`BASE_ADDR`, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0. The byte counter, k and N are all 0.
- Reset mid-operation: partial words and the count are discarded. Bytes offered while `rst`=1 are not accepted.
- Header latency: the 4th header byte accepted at edge t puts the block in `CHECK` during cycle t+1. It is in `LOAD`, `DONE` or `ERROR` at t+2.
- Word latency: the 4th byte of a word accepted at edge t gives `mem_we`=1 during cycle t+1. `in_ready`=0 in that cycle. `in_ready` returns at t+2 unless the block enters `DONE`.
- Peak throughput: 4 bytes per 5 cycles.
- `done` and `cpu_hold` change on the same edge that leaves the last `WRITE`.
- `in_valid` gaps of any length in any state stall progress without losing partial bytes.

## Structure
- `types_pkg` gains:
  - `BYTE` (logic [7:0])
  - `loader_state_t` enum (`HDR`, `CHECK`, `LOAD`, `WRITE`, `DONE`, `ERROR`)
  - `IMEM_BASE` constant, shared with the PC reset value.
- `DATA_BUS` comes from `types_pkg`.
- Sub-module `byte_assembler`:
  - shifts in bytes to form a little-endian word, with a 2-bit counter;
  - outputs `word` and a one-cycle `word_done`;
  - takes a `clear` input.
- It is reused for both the header and the data words. The FSM, k counter and address generation live in `imem_loader`.

## Test plan
- Reset, then header 02 00 00 00 and bytes 13 05 50 00 93 05 A0 00 → two `mem_we` pulses:
  - (32'h0, 32'h00500513)
  - (32'h4, 32'h00A00593)
  
  Then `done`=1, `cpu_hold`=0, `in_ready`=0.
- Header 00 00 00 00 → `DONE` two cycles after the 4th byte; no `mem_we` pulse.
- Header N=`DEPTH_WORDS`+1 → `error`=1, `cpu_hold` stays 1, `in_ready`=0, no writes.
- Load of 3 words with random `in_valid` gaps (0–5 cycles) → same writes as the gap-free run, each `mem_we` exactly one cycle with `in_ready`=0 in that cycle.
- Assert `rst` after 6 bytes of a 2-word load, then send the full 2-word stream → only the second stream's words are written, starting at `BASE_ADDR`.
- After `DONE`, hold `in_valid`=1 for 10 cycles → no acceptance, no `mem_we`, outputs unchanged.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types and constants for the fetch path and the boot-time loader.
package types_pkg;

    localparam int DATA_BUS = 32;

    typedef logic [7:0] BYTE;

    // Byte address of the first instruction; the PC resets to this value too.
    localparam logic [DATA_BUS-1:0] IMEM_BASE = 32'h0000_0000;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        CHECK = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port out.
//
// Handshake: a byte moves on a rising edge where in_valid && in_ready are
// both high; in_valid may drop at any time and in_data is only looked at on
// a transfer edge. mem_we is a one-cycle strobe with no back-pressure, and
// mem_addr/mem_wdata keep their last values while mem_we is low.
interface imem_loader_if;
    import types_pkg::*;

    BYTE                 in_data;
    logic                in_valid;
    logic                in_ready;
    logic                mem_we;
    logic [DATA_BUS-1:0] mem_addr;
    logic [DATA_BUS-1:0] mem_wdata;

    // Host side: drives bytes, observes the memory port.
    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted bytes into a little-endian word; the first byte ends up in
// bits 7:0. word_done flags the accept of the 4th byte, so the full word is
// on `word` from the following cycle on.
module byte_assembler
    import types_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  BYTE                 byte_in,
    input  logic                byte_valid,
    output logic [DATA_BUS-1:0] word,
    output logic                word_done
);

    logic [1:0] count;

    // Shift each accepted byte in from the top; the counter wraps 3->0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 2'd0;
            word  <= '0;
        end else if (byte_valid) begin
            word  <= {byte_in, word[DATA_BUS-1:8]};
            count <= count + 2'd1;
        end
    end

    assign word_done = byte_valid && (count == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: reads a word count and that many
// little-endian words from a byte stream, writes them from BASE_ADDR upward,
// and keeps the CPU in reset until the whole image is in memory.
module imem_loader
    import types_pkg::*;
#(
    parameter int                  DEPTH_WORDS = 1024,
    parameter logic [DATA_BUS-1:0] BASE_ADDR   = IMEM_BASE
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output loader_state_t dbg_state
);

    loader_state_t       cur_state;
    loader_state_t       next_state;
    logic [DATA_BUS-1:0] word_count;
    logic [DATA_BUS-1:0] word_index;
    logic [DATA_BUS-1:0] write_addr;
    logic [DATA_BUS-1:0] addr_hold;
    logic [DATA_BUS-1:0] wdata_hold;
    logic [DATA_BUS-1:0] asm_word;
    logic                asm_done;
    logic                accept;

    assign bus.in_ready = (cur_state == HDR) || (cur_state == LOAD);
    assign accept       = bus.in_valid && bus.in_ready;

    // The same assembler collects the header and every data word; it is
    // cleared in CHECK so data words start from an empty register.
    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (cur_state == CHECK),
        .byte_in    (bus.in_data),
        .byte_valid (accept),
        .word       (asm_word),
        .word_done  (asm_done)
    );

    assign write_addr = BASE_ADDR + {word_index[DATA_BUS-3:0], 2'b00};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) cur_state <= HDR;
        else     cur_state <= next_state;
    end

    // Next-state logic; header size is judged straight off the assembler.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            HDR:   if (asm_done) next_state = CHECK;
            CHECK: begin
                if (asm_word == '0)                              next_state = DONE;
                else if (asm_word > DATA_BUS'(DEPTH_WORDS))      next_state = ERROR;
                else                                             next_state = LOAD;
            end
            LOAD:  if (asm_done) next_state = WRITE;
            WRITE: begin
                if (word_index + 32'd1 == word_count) next_state = DONE;
                else                                  next_state = LOAD;
            end
            DONE:    next_state = DONE;
            ERROR:   next_state = ERROR;
            default: next_state = HDR;
        endcase
    end

    // Count register, word index and the held copies of the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
            word_index <= '0;
            addr_hold  <= BASE_ADDR;
            wdata_hold <= '0;
        end else begin
            if (cur_state == CHECK) word_count <= asm_word;
            if (cur_state == WRITE) begin
                word_index <= word_index + 32'd1;
                addr_hold  <= write_addr;
                wdata_hold <= asm_word;
            end
        end
    end

    assign bus.mem_we    = (cur_state == WRITE);
    assign bus.mem_addr  = (cur_state == WRITE) ? write_addr : addr_hold;
    assign bus.mem_wdata = (cur_state == WRITE) ? asm_word   : wdata_hold;

    assign cpu_hold  = (cur_state != DONE);
    assign done      = (cur_state == DONE);
    assign error     = (cur_state == ERROR);
    assign dbg_state = cur_state;

endmodule
